// File: rtl/mmreg_pkg.sv
// mmreg_pkg: shared types and next-state logic for the multi-mode register bank.
// Contents:
//   mode_t     - per-channel storage mode (D, T, JK, SR)
//   MAX_WIDTH  - widest supported channel; ff_next works at this width
//   ff_next()  - per-bit next value for a given mode, current q and inputs a/b
package mmreg_pkg;

    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned MODE_W    = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } mode_t;

    // Next stored value for an enabled update. Callers zero-extend to MAX_WIDTH
    // and truncate the result back to their channel width.
    function automatic logic [MAX_WIDTH-1:0] ff_next(
        input mode_t                mode,
        input logic [MAX_WIDTH-1:0] q,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b
    );
        logic [MAX_WIDTH-1:0] both;
        logic [MAX_WIDTH-1:0] nxt;
        both = a & b;
        nxt  = q;
        unique case (mode)
            MODE_D:  nxt = a;
            MODE_T:  nxt = q ^ a;
            MODE_JK: nxt = (a & ~q) | (~b & q);
            // S=R=1 bits keep q; all other bits follow set/reset.
            MODE_SR: nxt = ((a | (q & ~b)) & ~both) | (q & both);
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mmreg_channel.sv
// mmreg_channel: one WIDTH-bit storage channel of the multi-mode register bank.
// Ports:
//   ck, rst        - clock, asynchronous active-high reset
//   en_i, clr_i    - update enable, synchronous clear (clr has priority)
//   mode_i         - storage mode for this cycle
//   a_i, b_i       - primary (D/T/J/S) and secondary (K/R) inputs
//   q_o, qn_o      - stored value and its exact complement
//   changed_o      - high for one cycle after q changed
//   err_o          - sticky S=R=1 flag (only with MMREG_ILLEGAL_DET_EN, else 0)
module mmreg_channel
    import mmreg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  mode_t            mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qn_o,
    output logic             changed_o,
    output logic             err_o
);

    logic [WIDTH-1:0] q_q,  q_d;
    logic [WIDTH-1:0] qn_q;
    logic             changed_q, changed_d;

    // Next-state: clr > en > hold.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (en_i) begin
            q_d = WIDTH'(ff_next(mode_i, MAX_WIDTH'(q_q), MAX_WIDTH'(a_i), MAX_WIDTH'(b_i)));
        end
        changed_d = (q_d != q_q);
    end

    // qn is its own register loaded with ~q_d so it stays an exact complement.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            q_q       <= '0;
            qn_q      <= '1;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            qn_q      <= ~q_d;
            changed_q <= changed_d;
        end
    end

    assign q_o       = q_q;
    assign qn_o      = qn_q;
    assign changed_o = changed_q;

`ifdef MMREG_ILLEGAL_DET_EN
    logic err_q, err_d;

    // Sticky: set on an enabled SR update with any S=R=1 bit, cleared by clr.
    always_comb begin
        err_d = err_q;
        if (clr_i) begin
            err_d = 1'b0;
        end else if (en_i && (mode_i == MODE_SR) && (|(a_i & b_i))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: rtl/multi_mode_reg_bank.sv
// multi_mode_reg_bank: CHANNELS independent WIDTH-bit registers, each acting
// as a D, T, JK or SR flip-flop array selected per cycle by its mode field.
// Optional feature macro: MMREG_ILLEGAL_DET_EN (sticky S=R=1 detection on err).
// Ports:
//   ck, rst   - clock, asynchronous active-high reset
//   en, clr   - per-channel update enable / synchronous clear
//   mode      - 2 bits per channel, channel i at mode[2*i +: 2] (mode_t encoding)
//   a, b      - WIDTH bits per channel, channel i at [i*WIDTH +: WIDTH]
//   q, qn     - stored value and exact complement, same packing as a
//   changed   - per-channel one-cycle pulse after q changed
//   err       - per-channel sticky illegal-input flag (0 without the macro)
module multi_mode_reg_bank
    import mmreg_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                        ck,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         en,
    input  logic [CHANNELS-1:0]         clr,
    input  logic [MODE_W*CHANNELS-1:0]  mode,
    input  logic [WIDTH*CHANNELS-1:0]   a,
    input  logic [WIDTH*CHANNELS-1:0]   b,
    output logic [WIDTH*CHANNELS-1:0]   q,
    output logic [WIDTH*CHANNELS-1:0]   qn,
    output logic [CHANNELS-1:0]         changed,
    output logic [CHANNELS-1:0]         err
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        mmreg_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .ck        (ck),
            .rst       (rst),
            .en_i      (en[i]),
            .clr_i     (clr[i]),
            .mode_i    (mode_t'(mode[MODE_W*i +: MODE_W])),
            .a_i       (a[WIDTH*i +: WIDTH]),
            .b_i       (b[WIDTH*i +: WIDTH]),
            .q_o       (q[WIDTH*i +: WIDTH]),
            .qn_o      (qn[WIDTH*i +: WIDTH]),
            .changed_o (changed[i]),
            .err_o     (err[i])
        );
    end

endmodule

// File: tb/tb_multi_mode_reg_bank.sv
// tb_multi_mode_reg_bank: directed-vector bench for multi_mode_reg_bank
// (WIDTH=8, CHANNELS=4). Inputs are driven and outputs sampled 1 time unit
// after each rising edge of ck.
module tb_multi_mode_reg_bank;
    import mmreg_pkg::*;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned VW       = WIDTH * CHANNELS;

`ifdef MMREG_ILLEGAL_DET_EN
    localparam logic [CHANNELS-1:0] ERR3 = 4'b1000;
`else
    localparam logic [CHANNELS-1:0] ERR3 = 4'b0000;
`endif

    logic                ck;
    logic                rst;
    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] clr;
    logic [2*CHANNELS-1:0] mode;
    logic [VW-1:0]       a;
    logic [VW-1:0]       b;
    logic [VW-1:0]       q;
    logic [VW-1:0]       qn;
    logic [CHANNELS-1:0] changed;
    logic [CHANNELS-1:0] err;

    int checks = 0;
    int errors = 0;

    multi_mode_reg_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .ck      (ck),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .mode    (mode),
        .a       (a),
        .b       (b),
        .q       (q),
        .qn      (qn),
        .changed (changed),
        .err     (err)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic set_ch(input int ch, input mode_t m, input logic [7:0] av, input logic [7:0] bv);
        mode[2*ch +: 2]        = m;
        a[WIDTH*ch +: WIDTH]   = av;
        b[WIDTH*ch +: WIDTH]   = bv;
    endtask

    task automatic check_all(input string tag, input logic [31:0] eq, input logic [3:0] ech,
                             input logic [3:0] eerr);
        check({tag, ".q"},       q,       eq);
        check({tag, ".qn"},      qn,      ~eq);
        check({tag, ".changed"}, 32'(changed), 32'(ech));
        check({tag, ".err"},     32'(err),     32'(eerr));
    endtask

    initial begin
        rst  = 1'b1;
        en   = '0;
        clr  = '0;
        mode = '0;
        a    = '0;
        b    = '0;
        #1;
        check_all("reset", 32'h0000_0000, 4'b0000, 4'b0000);
        step();
        step();
        rst = 1'b0;

        // Asynchronous reset in mid-cycle discards stored 0xA5.
        en = 4'b0001;
        set_ch(0, MODE_D, 8'hA5, 8'h00);
        step();
        check("preload.q0", q, 32'h0000_00A5);
        en = '0;
        #3 rst = 1'b1;
        #1;
        check_all("async_rst", 32'h0000_0000, 4'b0000, 4'b0000);
        #1 rst = 1'b0;
        step();
        check_all("hold_after_rst", 32'h0000_0000, 4'b0000, 4'b0000);

        // Ch0 D load, then same value again gives no change pulse.
        en = 4'b0001;
        set_ch(0, MODE_D, 8'h3C, 8'hFF);
        step();
        check_all("d_load", 32'h0000_003C, 4'b0001, 4'b0000);
        step();
        check_all("d_same", 32'h0000_003C, 4'b0000, 4'b0000);

        // Ch1: D preload 0x0F, then T toggles with a mode switch at the same edge.
        en = 4'b0010;
        set_ch(1, MODE_D, 8'h0F, 8'h00);
        step();
        check("t_pre.q", q, 32'h0000_0F3C);
        set_ch(1, MODE_T, 8'hFF, 8'h00);
        step();
        check_all("t_1", 32'h0000_F03C, 4'b0010, 4'b0000);
        step();
        check_all("t_2", 32'h0000_0F3C, 4'b0010, 4'b0000);

        // Ch2: JK set/reset then toggle.
        en = 4'b0100;
        set_ch(2, MODE_D, 8'h0F, 8'h00);
        step();
        check("jk_pre.q", q, 32'h000F_0F3C);
        set_ch(2, MODE_JK, 8'hF0, 8'h0F);
        step();
        check_all("jk_setrst", 32'h00F0_0F3C, 4'b0100, 4'b0000);
        set_ch(2, MODE_JK, 8'hFF, 8'hFF);
        step();
        check_all("jk_toggle", 32'h000F_0F3C, 4'b0100, 4'b0000);

        // Ch3: SR with S=R=1 holds and (optionally) flags err, sticky until clr.
        en = 4'b1000;
        set_ch(3, MODE_SR, 8'h81, 8'h81);
        step();
        check_all("sr_illegal", 32'h000F_0F3C, 4'b0000, ERR3);
        set_ch(3, MODE_SR, 8'h00, 8'h00);
        step();
        check_all("sr_sticky", 32'h000F_0F3C, 4'b0000, ERR3);
        clr = 4'b1000;
        step();
        check_all("sr_clr", 32'h000F_0F3C, 4'b0000, 4'b0000);
        clr = 4'b0000;
        set_ch(3, MODE_SR, 8'h81, 8'h00);
        step();
        check_all("sr_set", 32'h810F_0F3C, 4'b1000, 4'b0000);
        set_ch(3, MODE_SR, 8'h00, 8'h01);
        step();
        check_all("sr_reset", 32'h800F_0F3C, 4'b1000, 4'b0000);

        // Clear ch0 while loading ch1 on the same edge; others unaffected.
        en  = 4'b0010;
        clr = 4'b0001;
        set_ch(1, MODE_D, 8'h55, 8'h00);
        step();
        check_all("indep", 32'h800F_5500, 4'b0011, 4'b0000);

        // Clear on an already-zero channel raises no change pulse; en=0 holds.
        en = 4'b0000;
        step();
        check_all("clr_zero", 32'h800F_5500, 4'b0000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
